mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one external memory port between the I-cache and D-cache miss/writeback paths.
//  Sits below both caches; the pipeline core is untouched.
//  Fixed D-over-I priority with a starvation guard for I.
//  Each accepted request is registered to memory and the response is returned to the owner only.
// PARAMETERS
//  ADDR_W    28   memory line address width
//  DATA_W    128  memory line width (one cache block)
//  MAX_WAIT  8    consecutive cycles I may lose arbitration before it is forced to win (>=1)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       asynchronous reset, ACTIVE-HIGH (1 = reset); name kept per port convention
//  i_read        in   1       I-cache line read request, held until i_ready
//  i_write       in   1       I-cache write request (normally 0, arbitrated like D)
//  i_addr        in   ADDR_W  I-cache line address
//  i_wdata       in   DATA_W  I-cache write line
//  i_rdata       out  DATA_W  line returned to I-cache
//  i_ready       out  1       one-cycle completion pulse to I-cache
//  d_read/d_write/d_addr/d_wdata/d_rdata/d_ready   same as i_*, for the D-cache
//  mem_read      out  1       to memory, registered
//  mem_write     out  1       to memory, registered
//  mem_addr      out  ADDR_W  registered address
//  mem_wdata     out  DATA_W  registered write line
//  mem_rdata     in   DATA_W  memory read line, valid with mem_ready
//  mem_ready     in   1       memory completion pulse
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 (mem_*, *_ready, *_rdata), wait_cnt=0.
//  Requester "active" = read|write. If both read and write are set, write wins (no read issued).
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: grant at the clock edge. Choose I if only I is active, or if both are active and wait_cnt==MAX_WAIT;
//   otherwise choose D if D is active. On grant, latch owner, mem_read/mem_write, addr, wdata -> BUSY.
//  BUSY: hold mem_* stable until mem_ready=1. On that edge, clear mem_read/mem_write, capture mem_rdata
//   into the owner's *_rdata, assert owner's *_ready -> RESP.
//  RESP: owner *_ready=1 for exactly this cycle; the other ready stays 0. Both requests ignored here
//   (owner still holds its stale request) -> IDLE. Latency is grant edge + memory latency + 1 cycle.
//  Non-owner *_rdata holds its last value. For a write, rdata is don't-care but still captured.
//  wait_cnt: +1 (saturating at MAX_WAIT) on each IDLE grant given to D while I is active.
//   Cleared when I is granted or when I is inactive in IDLE.
//  Requester inputs are sampled only in IDLE. A request dropped mid-BUSY does not abort the memory access.
//  mem_ready outside BUSY is ignored. Address and data pass through unmodified; width rules are identity.
//  Async reset mid-BUSY: outputs drop to 0 immediately and the transaction is abandoned; the caches are
//   reset by the same signal.
// STRUCTURE
//  Shared package: state enum {IDLE,BUSY,RESP}, owner encoding (OWN_I=0, OWN_D=1), default widths.
//  One natural sub-module, arb_starve_ctr (wait_cnt plus grant decision); the rest is a single FSM.
// TESTING
//  Reset: rst_n=1 with all inputs 0 -> all outputs 0, and they stay 0 while the inputs are idle.
//  I read only: i_read, i_addr=0x0000010, mem_ready after 3 cycles with rdata=0xA5..A5 -> mem_read one
//   cycle after the request; i_rdata=0xA5..A5 and i_ready pulses once; d_ready stays 0.
//  Simultaneous i_read and d_write (d_addr=0x20, d_wdata=0x1234) -> D serviced first (mem_write, addr 0x20),
//   then I. I grant comes 2 cycles after d_ready.
//  Starvation, MAX_WAIT=2: D re-requests continuously, I held -> I granted on the 3rd arbitration; wait_cnt=0 after.
//  Stale request: owner holds its request in RESP -> no second mem_read issued from RESP.
//  Reset mid-BUSY: mem_read=1, assert rst_n -> mem_read=0 without waiting for a clock; after release,
//   a fresh i_read is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, owner encoding, default widths.
// No logic; imported by the interface, the arbiter and its starvation counter.
// Widths here fix the interface; MAX_WAIT stays a module parameter.
package mem_arbiter_pkg;
    localparam int ADDR_W       = 28;
    localparam int DATA_W       = 128;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] line_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// master = arbiter view, slave = caches plus memory view.
// Requests are level-held until the matching one-cycle ready pulse.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  i_read;
    logic  i_write;
    addr_t i_addr;
    line_t i_wdata;
    line_t i_rdata;
    logic  i_ready;

    logic  d_read;
    logic  d_write;
    addr_t d_addr;
    line_t d_wdata;
    line_t d_rdata;
    logic  d_ready;

    logic  mem_read;
    logic  mem_write;
    addr_t mem_addr;
    line_t mem_wdata;
    line_t mem_rdata;
    logic  mem_ready;

    modport master (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Grant decision (D over I) with a saturating count of I's consecutive losses.
// Grant is combinational; the count updates on the arbitration edge.
// No backpressure: arb_en marks the cycles in which a grant is actually taken.
module arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   arb_en,
    input  logic   i_act,
    input  logic   d_act,
    output logic   grant_vld,
    output owner_t grant_own
);
    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        grant_vld  = i_act | d_act;
        grant_own  = (i_act && (!d_act || wait_cnt == CNT_MAX)) ? OWN_I : OWN_D;
        wait_cnt_d = wait_cnt;
        if (arb_en) begin
            // Only a loss to D while I is waiting counts toward starvation.
            if (!i_act || grant_own == OWN_I) begin
                wait_cnt_d = '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt_d = wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache; response goes to the owner only.
// Latency: grant edge + memory latency + 1 cycle; all outputs registered.
// Requests are held by the caches and sampled only in IDLE; memory stalls via mem_ready.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);
    state_t state, state_d;
    owner_t owner, owner_d;
    logic   mem_read_d, mem_write_d;
    addr_t  mem_addr_d;
    line_t  mem_wdata_d;
    line_t  i_rdata_d, d_rdata_d;
    logic   i_ready_d, d_ready_d;

    logic   i_act, d_act, grant_vld;
    owner_t grant_own;

    assign i_act = bus.i_read | bus.i_write;
    assign d_act = bus.d_read | bus.d_write;

    arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (state == IDLE),
        .i_act     (i_act),
        .d_act     (d_act),
        .grant_vld (grant_vld),
        .grant_own (grant_own)
    );

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        mem_read_d  = bus.mem_read;
        mem_write_d = bus.mem_write;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        i_rdata_d   = bus.i_rdata;
        d_rdata_d   = bus.d_rdata;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_own;
                    state_d = BUSY;
                    // A write takes precedence over a read raised in the same cycle.
                    if (grant_own == OWN_I) begin
                        mem_write_d = bus.i_write;
                        mem_read_d  = bus.i_read & ~bus.i_write;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = bus.i_wdata;
                    end else begin
                        mem_write_d = bus.d_write;
                        mem_read_d  = bus.d_read & ~bus.d_write;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                    if (owner == OWN_I) begin
                        i_rdata_d = bus.mem_rdata;
                        i_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = bus.mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end
            end
            // The owner still holds its stale request here; skip arbitration for one cycle.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            owner         <= OWN_I;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
        end else begin
            state         <= state_d;
            owner         <= owner_d;
            bus.mem_read  <= mem_read_d;
            bus.mem_write <= mem_write_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.i_rdata   <= i_rdata_d;
            bus.d_rdata   <= d_rdata_d;
            bus.i_ready   <= i_ready_d;
            bus.d_ready   <= d_ready_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized rounds against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int    MW = 2;
    localparam line_t A5 = {16{8'hA5}};

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
    endtask

    task automatic mem_respond(input int lat, input line_t data);
        repeat (lat) tick();
        bus.mem_rdata = data;
        bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
    endtask

    // Waits (bounded) for the arbiter to issue a memory operation.
    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (n < 8 && !ok) begin
            tick();
            ok = bus.mem_read | bus.mem_write;
            n++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1;
        repeat (2) tick();
        vecs++;
        if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0) begin
            errs++; $display("FAIL reset_ctl got %b want 0000", {bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready});
        end
        vecs++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            errs++; $display("FAIL reset_mem got addr %h wdata %h want 0", bus.mem_addr, bus.mem_wdata);
        end
        vecs++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errs++; $display("FAIL reset_rdata got i %h d %h want 0", bus.i_rdata, bus.d_rdata);
        end
        rst_n = 0;
        tick();
        // A stray memory completion while idle must be ignored.
        mem_respond(0, A5);
        repeat (2) tick();
        vecs++;
        if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0 || bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            errs++; $display("FAIL idle_quiet got ctl %b i %h d %h want all 0",
                             {bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}, bus.i_rdata, bus.d_rdata);
        end
    endtask

    task automatic test_i_read();
        bus.i_read = 1;
        bus.i_addr = 28'h0000010;
        tick();
        vecs++;
        if (bus.mem_read !== 1 || bus.mem_write !== 0 || bus.mem_addr !== 28'h0000010) begin
            errs++; $display("FAIL iread_issue got rd %b wr %b addr %h want 1 0 0000010", bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (bus.mem_read !== 1 || bus.mem_addr !== 28'h0000010 || bus.i_ready !== 0) begin
                errs++; $display("FAIL iread_hold got rd %b addr %h rdy %b want 1 0000010 0", bus.mem_read, bus.mem_addr, bus.i_ready);
            end
        end
        mem_respond(0, A5);
        vecs++;
        if (bus.i_ready !== 1 || bus.i_rdata !== A5) begin
            errs++; $display("FAIL iread_resp got rdy %b rdata %h want 1 %h", bus.i_ready, bus.i_rdata, A5);
        end
        vecs++;
        if (bus.d_ready !== 0 || bus.mem_read !== 0) begin
            errs++; $display("FAIL iread_other got d_ready %b mem_read %b want 0 0", bus.d_ready, bus.mem_read);
        end
        bus.i_read = 0;
        tick();
        vecs++;
        if (bus.i_ready !== 0) begin
            errs++; $display("FAIL iread_pulse got i_ready %b want 0", bus.i_ready);
        end
        tick();
    endtask

    task automatic test_both();
        bit ok;
        bus.i_read = 1; bus.i_addr = 28'h0000044;
        bus.d_write = 1; bus.d_addr = 28'h0000020; bus.d_wdata = 128'h1234;
        tick();
        vecs++;
        if (bus.mem_write !== 1 || bus.mem_read !== 0 || bus.mem_addr !== 28'h20 || bus.mem_wdata !== 128'h1234) begin
            errs++; $display("FAIL both_dfirst got wr %b rd %b addr %h wdata %h want 1 0 20 1234",
                             bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
        end
        mem_respond(1, 128'hBEEF);
        vecs++;
        if (bus.d_ready !== 1 || bus.i_ready !== 0) begin
            errs++; $display("FAIL both_dresp got d %b i %b want 1 0", bus.d_ready, bus.i_ready);
        end
        bus.d_write = 0;
        tick();
        vecs++;
        if (bus.mem_read !== 0) begin
            errs++; $display("FAIL both_gap got mem_read %b want 0", bus.mem_read);
        end
        tick();
        vecs++;
        if (bus.mem_read !== 1 || bus.mem_addr !== 28'h44) begin
            errs++; $display("FAIL both_igrant got rd %b addr %h want 1 44", bus.mem_read, bus.mem_addr);
        end
        mem_respond(0, 128'h77);
        vecs++;
        if (bus.i_ready !== 1 || bus.i_rdata !== 128'h77 || bus.d_ready !== 0) begin
            errs++; $display("FAIL both_iresp got i %b rdata %h d %b want 1 77 0", bus.i_ready, bus.i_rdata, bus.d_ready);
        end
        bus.i_read = 0;
        ok = 0;
        repeat (2) tick();
    endtask

    task automatic test_starve();
        bit ok;
        bus.i_read = 1; bus.i_addr = 28'h0000100;
        bus.d_read = 1; bus.d_addr = 28'h0000200;
        for (int k = 0; k < 3; k++) begin
            wait_grant(ok);
            vecs++;
            if (!ok || bus.mem_addr !== ((k == 2) ? 28'h100 : 28'h200)) begin
                errs++; $display("FAIL starve_grant%0d got ok %b addr %h want %h", k, ok, bus.mem_addr, (k == 2) ? 28'h100 : 28'h200);
            end
            if (k == 2) begin
                vecs++;
                if (dut.u_ctr.wait_cnt !== 0) begin
                    errs++; $display("FAIL starve_clear got wait_cnt %0d want 0", dut.u_ctr.wait_cnt);
                end
            end
            mem_respond(1, line_t'(k));
            vecs++;
            if ({bus.i_ready, bus.d_ready} !== ((k == 2) ? 2'b10 : 2'b01)) begin
                errs++; $display("FAIL starve_resp%0d got i,d %b want %b", k, {bus.i_ready, bus.d_ready}, (k == 2) ? 2'b10 : 2'b01);
            end
        end
        bus.i_read = 0; bus.d_read = 0;
        repeat (2) tick();
    endtask

    task automatic test_stale();
        bus.i_read = 1; bus.i_addr = 28'h0000030;
        tick();
        mem_respond(0, 128'h55);
        vecs++;
        if (bus.i_ready !== 1) begin
            errs++; $display("FAIL stale_resp got i_ready %b want 1", bus.i_ready);
        end
        tick();
        vecs++;
        if (bus.mem_read !== 0 || bus.i_ready !== 0) begin
            errs++; $display("FAIL stale_reissue got mem_read %b i_ready %b want 0 0", bus.mem_read, bus.i_ready);
        end
        bus.i_read = 0;
        tick();
        vecs++;
        if (bus.mem_read !== 0) begin
            errs++; $display("FAIL stale_idle got mem_read %b want 0", bus.mem_read);
        end
        tick();
    endtask

    task automatic test_reset_busy();
        bus.i_read = 1; bus.i_addr = 28'h0000040;
        tick();
        vecs++;
        if (bus.mem_read !== 1) begin
            errs++; $display("FAIL rstbusy_pre got mem_read %b want 1", bus.mem_read);
        end
        #2 rst_n = 1;
        #1;
        vecs++;
        if (bus.mem_read !== 0 || bus.mem_addr !== '0) begin
            errs++; $display("FAIL rstbusy_async got mem_read %b addr %h want 0 0", bus.mem_read, bus.mem_addr);
        end
        bus.i_read = 0;
        tick();
        rst_n = 0;
        tick();
        bus.i_read = 1; bus.i_addr = 28'h0000041;
        tick();
        vecs++;
        if (bus.mem_read !== 1 || bus.mem_addr !== 28'h41) begin
            errs++; $display("FAIL rstbusy_fresh got rd %b addr %h want 1 41", bus.mem_read, bus.mem_addr);
        end
        mem_respond(2, 128'h99);
        vecs++;
        if (bus.i_ready !== 1 || bus.i_rdata !== 128'h99) begin
            errs++; $display("FAIL rstbusy_resp got rdy %b rdata %h want 1 99", bus.i_ready, bus.i_rdata);
        end
        bus.i_read = 0;
        repeat (2) tick();
    endtask

    // Model: each side is a held request; D wins unless I has already lost MW times in a row.
    task automatic test_random();
        bit         ip, dp, own_i, ok;
        logic [1:0] iop, dop, op;
        addr_t      ia, da, ea;
        line_t      iw, dw, ew, rd, last_i, last_d;
        int         losses, lat;
        ip = 0; dp = 0; losses = 0; last_i = '0; last_d = '0;
        clear_inputs();
        rst_n = 1;
        tick();
        rst_n = 0;
        tick();
        for (int r = 0; r < 150; r++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1;
                iop = ($urandom_range(0, 5) == 0) ? 2'b11 : (($urandom_range(0, 4) == 0) ? 2'b10 : 2'b01);
                ia = addr_t'($urandom); iw = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!dp && ($urandom_range(0, 2) != 0 || !ip)) begin
                dp = 1;
                dop = 2'($urandom_range(1, 3));
                da = addr_t'($urandom); dw = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.i_read = ip & iop[0]; bus.i_write = ip & iop[1]; bus.i_addr = ia; bus.i_wdata = iw;
            bus.d_read = dp & dop[0]; bus.d_write = dp & dop[1]; bus.d_addr = da; bus.d_wdata = dw;
            own_i = ip && (!dp || losses == MW);
            op = own_i ? iop : dop;
            ea = own_i ? ia : da;
            ew = own_i ? iw : dw;
            if (!ip || own_i) losses = 0;
            else if (losses < MW) losses++;
            wait_grant(ok);
            vecs++;
            if (!ok || bus.mem_write !== op[1] || bus.mem_read !== (op[0] & ~op[1])) begin
                errs++; $display("FAIL rnd%0d_op got ok %b rd %b wr %b want op %b", r, ok, bus.mem_read, bus.mem_write, op);
            end
            if (!ok) break;
            vecs++;
            if (bus.mem_addr !== ea || bus.mem_wdata !== ew) begin
                errs++; $display("FAIL rnd%0d_bus got addr %h wdata %h want %h %h", r, bus.mem_addr, bus.mem_wdata, ea, ew);
            end
            lat = $urandom_range(0, 3);
            for (int k = 0; k < lat; k++) begin
                tick();
                vecs++;
                if (bus.mem_addr !== ea || bus.mem_write !== op[1] || (bus.i_ready | bus.d_ready) !== 0) begin
                    errs++; $display("FAIL rnd%0d_hold got addr %h wr %b rdy %b%b want %h %b 00",
                                     r, bus.mem_addr, bus.mem_write, bus.i_ready, bus.d_ready, ea, op[1]);
                end
            end
            rd = {$urandom, $urandom, $urandom, $urandom};
            mem_respond(0, rd);
            if (own_i) last_i = rd; else last_d = rd;
            vecs++;
            if ({bus.i_ready, bus.d_ready} !== (own_i ? 2'b10 : 2'b01) || (bus.mem_read | bus.mem_write) !== 0) begin
                errs++; $display("FAIL rnd%0d_ready got i,d %b mem %b%b want %b 00", r, {bus.i_ready, bus.d_ready},
                                 bus.mem_read, bus.mem_write, own_i ? 2'b10 : 2'b01);
            end
            vecs++;
            if (bus.i_rdata !== last_i || bus.d_rdata !== last_d) begin
                errs++; $display("FAIL rnd%0d_rdata got i %h d %h want %h %h", r, bus.i_rdata, bus.d_rdata, last_i, last_d);
            end
            if (own_i) begin ip = 0; bus.i_read = 0; bus.i_write = 0; end
            else begin dp = 0; bus.d_read = 0; bus.d_write = 0; end
        end
        clear_inputs();
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_both();
        test_starve();
        test_stale();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
